// File: rtl/pmem_arbiter.sv
// Two-client arbiter that shares one line-granular physical memory port
// between the I-cache and D-cache, round-robin on conflict.
module pmem_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int LINE_WIDTH  = 128,
  parameter int OFFSET_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic                  i_pmem_resp,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic                  d_pmem_resp,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [LINE_WIDTH-1:0] pmem_rdata
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

  state_t                state_reg, state_next;
  logic                  op_write_reg, op_write_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [LINE_WIDTH-1:0] wdata_reg, wdata_next;
  logic                  last_grant_reg, last_grant_next;  // 1 = D-cache was granted last

  logic d_req;
  logic grant_d;

  assign d_req   = d_pmem_read | d_pmem_write;
  // On conflict the client that was not granted last wins.
  assign grant_d = d_req & (~i_pmem_read | ~last_grant_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      op_write_reg   <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      last_grant_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      op_write_reg   <= op_write_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    op_write_next   = op_write_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    last_grant_next = last_grant_reg;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    pmem_address    = addr_reg;
    pmem_wdata      = wdata_reg;
    i_pmem_resp     = 1'b0;
    d_pmem_resp     = 1'b0;
    i_pmem_rdata    = pmem_rdata;
    d_pmem_rdata    = pmem_rdata;

    case (state_reg)
      IDLE: begin
        if (i_pmem_read || d_req) begin
          last_grant_next = grant_d;
          wdata_next      = d_pmem_wdata;
          if (grant_d) begin
            addr_next     = d_pmem_address & LINE_MASK;
            op_write_next = d_pmem_write;  // write wins over an overlapping read
            state_next    = SERVE_D;
          end else begin
            addr_next     = i_pmem_address & LINE_MASK;
            op_write_next = 1'b0;
            state_next    = SERVE_I;
          end
        end
      end
      SERVE_I: begin
        pmem_read  = ~op_write_reg;
        pmem_write = op_write_reg;
        if (pmem_resp) begin
          i_pmem_resp = 1'b1;
          state_next  = DONE;
        end
      end
      SERVE_D: begin
        pmem_read  = ~op_write_reg;
        pmem_write = op_write_reg;
        if (pmem_resp) begin
          d_pmem_resp = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Outputs are quiet for the whole cycle in which reset is sampled.
    if (reset) begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      i_pmem_resp  = 1'b0;
      d_pmem_resp  = 1'b0;
      i_pmem_rdata = '0;
      d_pmem_rdata = '0;
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed table-driven bench for pmem_arbiter plus hand-written reset corner.
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_pmem_read;
  logic [15:0]  i_pmem_address;
  logic         i_pmem_resp;
  logic [127:0] i_pmem_rdata;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata;
  logic         d_pmem_resp;
  logic [127:0] d_pmem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  int checks = 0;
  int failures = 0;

  pmem_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128), .OFFSET_BITS(4)) dut (
    .clk(clk), .reset(reset),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_resp(i_pmem_resp), .i_pmem_rdata(i_pmem_rdata),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_resp(d_pmem_resp), .d_pmem_rdata(d_pmem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         i_rd;
    logic         d_rd;
    logic         d_wr;
    logic [15:0]  i_addr;
    logic [15:0]  d_addr;
    logic [127:0] d_wdata;
    logic [127:0] rdata;
    int           delay;
    logic         exp_d;
    logic         exp_wr;
    logic [15:0]  exp_addr;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b1, 16'h2000, 16'h4008, {4{32'hA5A5_0001}}, {4{32'h1111_0000}}, 2, 1'b1, 1'b1, 16'h4000};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h2000, 16'h4008, {4{32'hA5A5_0001}}, {4{32'h2222_0000}}, 1, 1'b0, 1'b0, 16'h2000};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h3104, 16'h5555, {4{32'h0}},         {4{32'h3333_0000}}, 0, 1'b1, 1'b0, 16'h5550};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h3104, 16'h5555, {4{32'h0}},         {4{32'h4444_0000}}, 4, 1'b0, 1'b0, 16'h3100};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h1237, 16'h0000, {4{32'h0}},         {4{32'hDEAD_BEEF}}, 2, 1'b0, 1'b0, 16'h1230};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h7FFF, {4{32'hC0DE_F00D}}, {4{32'h5555_0000}}, 1, 1'b1, 1'b1, 16'h7FF0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h0020, {4{32'h0}},         {4{32'h6666_0000}}, 1, 1'b0, 1'b0, 16'h0010};

    reset = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    tick();
    tick();
    @(negedge clk);
    check("reset_pmem_read", pmem_read, 0);
    check("reset_pmem_write", pmem_write, 0);
    check("reset_i_resp", i_pmem_resp, 0);
    check("reset_d_resp", d_pmem_resp, 0);
    tick();
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      i_pmem_read    = vecs[v].i_rd;
      i_pmem_address = vecs[v].i_addr;
      d_pmem_read    = vecs[v].d_rd;
      d_pmem_write   = vecs[v].d_wr;
      d_pmem_address = vecs[v].d_addr;
      d_pmem_wdata   = vecs[v].d_wdata;
      @(negedge clk);
      check($sformatf("v%0d_idle_rd", v), pmem_read, 0);
      check($sformatf("v%0d_idle_wr", v), pmem_write, 0);
      tick();
      @(negedge clk);
      check($sformatf("v%0d_serve_rd", v), pmem_read, !vecs[v].exp_wr);
      check($sformatf("v%0d_serve_wr", v), pmem_write, vecs[v].exp_wr);
      check($sformatf("v%0d_serve_addr", v), pmem_address, vecs[v].exp_addr);
      if (vecs[v].exp_wr)
        check($sformatf("v%0d_serve_wdata", v), pmem_wdata, vecs[v].d_wdata);
      for (int w = 0; w < vecs[v].delay; w++) begin
        tick();
        d_pmem_address = 16'($urandom);
        d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
        i_pmem_address = 16'($urandom);
        @(negedge clk);
        check($sformatf("v%0d_hold_addr", v), pmem_address, vecs[v].exp_addr);
        if (vecs[v].exp_wr)
          check($sformatf("v%0d_hold_wdata", v), pmem_wdata, vecs[v].d_wdata);
        check($sformatf("v%0d_wait_resp", v), {i_pmem_resp, d_pmem_resp}, 2'b00);
      end
      pmem_resp  = 1'b1;
      pmem_rdata = vecs[v].rdata;
      #1;
      check($sformatf("v%0d_resp_i", v), i_pmem_resp, !vecs[v].exp_d);
      check($sformatf("v%0d_resp_d", v), d_pmem_resp, vecs[v].exp_d);
      check($sformatf("v%0d_rdata", v), vecs[v].exp_d ? d_pmem_rdata : i_pmem_rdata, vecs[v].rdata);
      tick();
      pmem_resp = 1'b0;
      if (vecs[v].exp_d) begin
        d_pmem_read = 1'b0; d_pmem_write = 1'b0;
      end else begin
        i_pmem_read = 1'b0;
      end
      @(negedge clk);
      check($sformatf("v%0d_done_req", v), {pmem_read, pmem_write}, 2'b00);
      check($sformatf("v%0d_done_resp", v), {i_pmem_resp, d_pmem_resp}, 2'b00);
      tick();
    end

    // Reset in the middle of an I-cache transaction, late memory response ignored.
    i_pmem_read = 1'b1; i_pmem_address = 16'h0ABC;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    tick();
    @(negedge clk);
    check("rst_serve_rd", pmem_read, 1);
    check("rst_serve_addr", pmem_address, 16'h0AB0);
    reset = 1'b1;
    #1;
    check("rst_outputs_rd", pmem_read, 0);
    check("rst_outputs_addr", pmem_address, 0);
    tick();
    reset = 1'b0;
    i_pmem_read = 1'b0;
    pmem_resp = 1'b1;
    pmem_rdata = {4{32'hBAD0_BAD0}};
    @(negedge clk);
    check("rst_late_i_resp", i_pmem_resp, 0);
    check("rst_late_d_resp", d_pmem_resp, 0);
    check("rst_late_rd", pmem_read, 0);
    tick();
    pmem_resp = 1'b0;
    @(negedge clk);
    check("rst_idle_rd", {pmem_read, pmem_write}, 2'b00);
    tick();
    i_pmem_read = 1'b1; i_pmem_address = 16'h0100;
    d_pmem_read = 1'b1; d_pmem_address = 16'h0200;
    tick();
    @(negedge clk);
    check("rst_conflict_addr", pmem_address, 16'h0200);
    check("rst_conflict_rd", pmem_read, 1);
    pmem_resp = 1'b1;
    #1;
    check("rst_conflict_d_resp", d_pmem_resp, 1);
    tick();
    pmem_resp = 1'b0;
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Sits directly downstream of the instruction cache and data cache.
- Multiplexes their line-granular physical-memory requests onto the single physical memory port.
- Grants one cache at a time, holds the granted request stable until physical memory responds, then routes the response back to that cache only.
- Round-robin on conflict so neither cache starves.

Parameters:
ADDR_WIDTH, 16, byte address width (lc3b_pmem_addr)
LINE_WIDTH, 128, cache line width in bits (lc3b_pmem_line)
OFFSET_BITS, 4, line offset bits forced to zero on the memory address

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
i_pmem_read  input  1  I-cache line read request (level, held until i_pmem_resp)
i_pmem_address  input  ADDR_WIDTH  I-cache line address
i_pmem_resp  output  1  one-cycle completion pulse to I-cache
i_pmem_rdata  output  LINE_WIDTH  line data to I-cache, valid while i_pmem_resp=1
d_pmem_read  input  1  D-cache line fill request
d_pmem_write  input  1  D-cache writeback request
d_pmem_address  input  ADDR_WIDTH  D-cache line address
d_pmem_wdata  input  LINE_WIDTH  D-cache writeback line
d_pmem_resp  output  1  one-cycle completion pulse to D-cache
d_pmem_rdata  output  LINE_WIDTH  line data to D-cache, valid while d_pmem_resp=1
pmem_read  output  1  read request to physical memory
pmem_write  output  1  write request to physical memory
pmem_address  output  ADDR_WIDTH  line-aligned address to physical memory
pmem_wdata  output  LINE_WIDTH  write line to physical memory
pmem_resp  input  1  physical memory completion
pmem_rdata  input  LINE_WIDTH  physical memory read line

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, DONE. Registers: state, owner op (read/write), latched address, latched wdata, last_grant (I/D).
- Reset (synchronous):
  - state=IDLE, last_grant=I, latched address/wdata=0.
  - All outputs 0 in the same cycle reset is sampled high.
  - Reset mid-transaction abandons it. No resp is issued. A pmem_resp arriving later while in IDLE is ignored.
- IDLE:
  - pmem_read=pmem_write=0.
  - Request from one cache only: grant it.
  - Both request: grant the one not equal to last_grant. After reset, the first conflict goes to D.
  - On grant, latch address with low OFFSET_BITS cleared, plus wdata and op. Update last_grant. Next state SERVE_I or SERVE_D.
- D-cache op select: d_pmem_write=1 means write, even if d_pmem_read=1 (illegal overlap, write wins). Otherwise read. I-cache is always a read.
- SERVE_I / SERVE_D:
  - Drive pmem_read or pmem_write from the latched op, with pmem_address and pmem_wdata from the latches.
  - These outputs stay constant regardless of requester input changes.
- Response routing:
  - On pmem_resp=1, pulse the owner's *_pmem_resp combinationally in that same cycle, and pass pmem_rdata to the owner's *_pmem_rdata.
  - The non-owner resp stays 0.
  - Next state DONE.
- DONE:
  - One cooldown cycle with all pmem requests 0.
  - Requests are ignored so the served cache can drop its level request. Next state IDLE.
- Latency: request first seen in IDLE at cycle 0 → pmem_* asserted at cycle 1 → resp to owner in the cycle pmem_resp arrives (k) → DONE at k+1 → IDLE at k+2. Earliest next grant is sampled at k+2.
- rdata outputs: *_pmem_rdata may mirror pmem_rdata continuously. Caches must qualify with resp.
- pmem_wdata on reads: don't-care, but driven from the latch (no X).
- Requests that drop before grant are not remembered.

Test Plan:
- I-only read: i_pmem_read=1, addr 0x1237; memory responds 3 cycles after request → pmem_read=1 with pmem_address=0x1230; i_pmem_resp pulses exactly one cycle carrying rdata 0xDEAD...BEEF; d_pmem_resp stays 0; idle at k+2.
- Simultaneous I read 0x2000 and D write 0x4008 right after reset → D granted first (pmem_write, addr 0x4000, wdata latched); after DONE, I granted (pmem_read, addr 0x2000).
- Sustained conflict for 4 transactions → grants alternate D, I, D, I; neither waits more than one transaction.
- D changes d_pmem_address/wdata mid-SERVE_D → pmem_address/pmem_wdata unchanged until pmem_resp.
- d_pmem_read=d_pmem_write=1 → pmem_write=1, pmem_read=0.
- reset asserted during SERVE_I, then pmem_resp one cycle later → outputs 0 next cycle; no i_pmem_resp pulse; arbiter in IDLE with last_grant=I.
